// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the redirect pipeline stage registers: stage states,
// perf counter width, per-stage channel counts and the default reset value.
package pipe_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_t;

  localparam int unsigned PERF_CNT_W = 32;

  localparam int unsigned IF_ID_CH  = 4;
  localparam int unsigned ID_EX_CH  = 4;
  localparam int unsigned EX_MEM_CH = 4;
  localparam int unsigned MEM_WB_CH = 4;

  localparam logic [31:0] DEF_RESET_VAL = 32'h0000_0000;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake/data bundle between a pipeline stage register and its neighbours.
// master = surrounding pipeline control, slave = the stage register itself.
interface pipe_stage_reg_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4
);
  import pipe_pkg::*;

  logic                          stall_in;
  logic                          flush_in;
  logic                          valid_in;
  logic [CHANNELS-1:0]           chan_we_in;
  logic [CHANNELS*WIDTH-1:0]     data_in;
  logic                          valid_out;
  logic [CHANNELS*WIDTH-1:0]     data_out;
  logic [PERF_CNT_W-1:0]         stall_cnt_out;
  logic [PERF_CNT_W-1:0]         kill_cnt_out;

  modport master (
    output stall_in, flush_in, valid_in, chan_we_in, data_in,
    input  valid_out, data_out, stall_cnt_out, kill_cnt_out
  );

  modport slave (
    input  stall_in, flush_in, valid_in, chan_we_in, data_in,
    output valid_out, data_out, stall_cnt_out, kill_cnt_out
  );
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter with synchronous clear; sticks at all-ones.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int unsigned W = PERF_CNT_W
) (
  input  logic         clk_in,
  input  logic         clr_in,
  input  logic         en_in,
  output logic [W-1:0] cnt_out
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_in) begin
    if (clr_in) begin
      cnt_q <= '0;
    end else if (en_in && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_out = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall, flush, bubble and per-channel load.
// Define PIPE_STAGE_PERF_EN to build the stall/kill saturating counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      CHANNELS  = IF_ID_CH,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL)
) (
  input logic             clk_in,
  input logic             rst_in,
  pipe_stage_reg_if.slave bus
);

  stage_state_t state_q, state_d;
  logic         clear_all;

  always_comb begin
    state_d   = state_q;
    clear_all = 1'b0;
    if (bus.flush_in) begin
      state_d   = ST_EMPTY;
      clear_all = 1'b1;
    end else if (!bus.stall_in) begin
      state_d   = bus.valid_in ? ST_FULL : ST_EMPTY;
      clear_all = !bus.valid_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.valid_out = (state_q == ST_FULL);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic [WIDTH-1:0] ch_q;
    logic             ch_load;

    // Flush and bubble already cover the clear case, so a load needs no stall/valid recheck beyond this.
    assign ch_load = !bus.flush_in && !bus.stall_in && bus.valid_in && bus.chan_we_in[i];

    always_ff @(posedge clk_in) begin
      if (rst_in || clear_all) begin
        ch_q <= RESET_VAL;
      end else if (ch_load) begin
        ch_q <= bus.data_in[i*WIDTH +: WIDTH];
      end
    end

    assign bus.data_out[i*WIDTH +: WIDTH] = ch_q;
  end

`ifdef PIPE_STAGE_PERF_EN
  logic stall_evt;
  logic kill_evt;

  assign stall_evt = bus.stall_in && !bus.flush_in && bus.valid_out;
  assign kill_evt  = bus.flush_in && bus.valid_out;

  sat_counter #(.W(PERF_CNT_W)) u_stall_cnt (
    .clk_in (clk_in),
    .clr_in (rst_in),
    .en_in  (stall_evt),
    .cnt_out(bus.stall_cnt_out)
  );

  sat_counter #(.W(PERF_CNT_W)) u_kill_cnt (
    .clk_in (clk_in),
    .clr_in (rst_in),
    .en_in  (kill_evt),
    .cnt_out(bus.kill_cnt_out)
  );
`else
  assign bus.stall_cnt_out = '0;
  assign bus.kill_cnt_out  = '0;
`endif

endmodule
